// File: rtl/bus_pkg.sv
// Shared types and sizing helpers for the round-robin bus arbiter.
package bus_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_WAIT_BEGIN,
    ARB_BUSY,
    ARB_ERROR
  } arb_state_e;

  localparam int DEFAULT_NUM_MASTERS    = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 256;
  localparam int DEFAULT_BEGIN_TIMEOUT  = 16;

  // A single master still needs a one-bit owner index.
  function automatic int owner_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int a, input int b);
    return (a > b) ? $clog2(a) : $clog2(b);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_select.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_select
  import bus_pkg::*;
#(
  parameter int N = DEFAULT_NUM_MASTERS,
  parameter int W = owner_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         valid
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W:0]     sum;

  // rot[i] is the request of master (ptr + i) mod N.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    // Scan downward so the smallest offset from ptr is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, ptr} + (W + 1)'(i);
        if (sum >= (W + 1)'(N)) begin
          sum = sum - (W + 1)'(N);
        end
        winner = sum[W-1:0];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with grant pulse, ownership tracking and watchdogs.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter  int NUM_MASTERS    = DEFAULT_NUM_MASTERS,
  parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter  int BEGIN_TIMEOUT  = DEFAULT_BEGIN_TIMEOUT,
  localparam int OWNER_W        = owner_w(NUM_MASTERS),
  localparam int CNT_W          = cnt_w(TIMEOUT_CYCLES, BEGIN_TIMEOUT)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] bus_request,
  input  logic                   begin_transaction,
  input  logic                   end_transaction,
  output logic [NUM_MASTERS-1:0] bus_aquire,
  output logic                   bus_error,
  output logic [OWNER_W-1:0]     owner_id,
  output logic                   bus_busy,
  output arb_state_e             dbg_state
);

  // Handshake: a master holds bus_request high until it sees its one-cycle
  // bus_aquire pulse; it then strobes begin_transaction, and the bus is
  // released by end_transaction (or withdrawal / timeout / watchdog).

  localparam logic [CNT_W-1:0] BEGIN_LAST = CNT_W'(BEGIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e             state_q, state_d;
  logic [OWNER_W-1:0]     owner_q, owner_d;
  logic [OWNER_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] aquire_q, aquire_d;
  logic                   error_q, error_d;
  logic                   busy_q, busy_d;

  logic [OWNER_W-1:0]     win_id;
  logic                   win_valid;
  logic                   owner_req;
  logic [CNT_W-1:0]       cnt_inc;

  rr_select #(
    .N (NUM_MASTERS),
    .W (OWNER_W)
  ) u_rr_select (
    .req    (bus_request),
    .ptr    (rr_ptr_q),
    .winner (win_id),
    .valid  (win_valid)
  );

  assign owner_req = |(bus_request & (NUM_MASTERS'(1) << owner_q));
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (win_valid) begin
          state_d  = ARB_GRANT;
          owner_d  = win_id;
          rr_ptr_d = (win_id == OWNER_W'(NUM_MASTERS - 1)) ? '0 : win_id + 1'b1;
        end
      end
      // A begin strobe arriving during the grant pulse is honoured immediately.
      ARB_GRANT, ARB_WAIT_BEGIN: begin
        if (begin_transaction) begin
          state_d = end_transaction ? ARB_IDLE : ARB_BUSY;
          cnt_d   = '0;
        end else if (state_q == ARB_GRANT) begin
          state_d = ARB_WAIT_BEGIN;
          cnt_d   = '0;
        end else if (!owner_req || cnt_q == BEGIN_LAST) begin
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ARB_BUSY: begin
        if (end_transaction) begin
          state_d = ARB_IDLE;
        end else if (cnt_q == BUSY_LAST) begin
          state_d = ARB_ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ARB_ERROR: state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase

    aquire_d = (state_q == ARB_IDLE && win_valid) ? (NUM_MASTERS'(1) << win_id) : '0;
    error_d  = (state_d == ARB_ERROR);
    busy_d   = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      aquire_q <= '0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      aquire_q <= aquire_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
    end
  end

  assign bus_aquire = aquire_q;
  assign bus_error  = error_q;
  assign owner_id   = owner_q;
  assign bus_busy   = busy_q;
  assign dbg_state  = state_q;

endmodule
